// File: rtl/wb_dfx_sequencer.sv
// Wishbone-programmed sequencer that walks a DFX controller through a partial reconfiguration:
// bitstream address, size, trigger, then status polling. Define DFX_SEQ_TIMEOUT_EN to bound the polling.
module wb_dfx_sequencer #(
    parameter logic [4:0]  STAT_OFS      = 5'd0,
    parameter logic [4:0]  BS_ADDR_OFS   = 5'd6,
    parameter logic [4:0]  BS_SIZE_OFS   = 5'd7,
    parameter logic [31:0] TRIG_CMD      = 32'h0000_0001,
    parameter int unsigned POLL_INTERVAL = 64,
    parameter logic [15:0] TIMEOUT_POLLS = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  wbs_adr,
    input  logic [31:0] wbs_dat_w,
    output logic [31:0] wbs_dat_r,
    input  logic [3:0]  wbs_sel,
    input  logic        wbs_cyc,
    input  logic        wbs_stb,
    input  logic        wbs_we,
    output logic        wbs_ack,
    output logic        wbs_stall,
    output logic        wbs_err,
    output logic [4:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_stall_i,
    input  logic        wbm_err_i,
    output logic        irq_o
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_BS_ADDR = 3'd2;
    localparam logic [2:0] A_BS_SIZE = 3'd3;
    localparam logic [2:0] A_LAST    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_SIZE, S_WR_TRIG, S_WAIT, S_RD_STAT, S_FIN
    } state_t;

    state_t      state_reg;
    state_t      bus_next;
    logic        busy;
    logic        wbs_req;
    logic        wbs_wr;
    logic        start_req;
    logic        cfg_wr_ok;
    logic [3:0]  w1c_mask;

    logic        ack_reg;
    logic        irq_reg;
    logic        irq_en_reg;
    logic [31:0] dat_r_reg;
    logic [31:0] rd_data;
    logic [31:0] bs_addr_reg;
    logic [31:0] bs_addr_next;
    logic [31:0] bs_size_reg;
    logic [31:0] bs_size_next;
    logic [31:0] last_stat_reg;
    logic        done_reg;
    logic        err_reg;
    logic        bus_err_reg;
    logic        timeout_bit;

    logic        cyc_reg;
    logic        stb_reg;
    logic        we_reg;
    logic [4:0]  adr_reg;
    logic [31:0] dat_reg;
    logic [4:0]  bus_adr;
    logic [31:0] bus_dat;
    logic        bus_we;
    logic [31:0] wait_cnt_reg;

`ifdef DFX_SEQ_TIMEOUT_EN
    logic        timeout_reg;
    logic [15:0] poll_cnt_reg;
    logic [15:0] poll_cnt_next;
    assign poll_cnt_next = poll_cnt_reg + 16'd1;
    assign timeout_bit   = timeout_reg;
`else
    assign timeout_bit = 1'b0;
    wire unused_cfg = ^{TIMEOUT_POLLS, w1c_mask[2]};
`endif

    assign busy      = (state_reg != S_IDLE);
    assign wbs_req   = wbs_cyc & wbs_stb;
    assign wbs_wr    = wbs_req & wbs_we;
    assign cfg_wr_ok = wbs_wr & ~busy;
    assign start_req = wbs_wr && (wbs_adr == A_CTRL) && wbs_sel[0] && wbs_dat_w[0] && !busy;
    assign w1c_mask  = (wbs_wr && (wbs_adr == A_STATUS) && wbs_sel[0]) ? wbs_dat_w[4:1] : 4'b0000;

    assign wbs_ack   = ack_reg;
    assign wbs_dat_r = dat_r_reg;
    assign wbs_stall = 1'b0;
    assign wbs_err   = 1'b0;
    assign irq_o     = irq_reg;

    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = stb_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;
    assign wbm_sel_o = 4'hF;

    // Byte-lane merge for the bitstream registers; writes are dropped while a run is active.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign bs_addr_next[gi*8 +: 8] = (cfg_wr_ok && (wbs_adr == A_BS_ADDR) && wbs_sel[gi])
                                         ? wbs_dat_w[gi*8 +: 8] : bs_addr_reg[gi*8 +: 8];
        assign bs_size_next[gi*8 +: 8] = (cfg_wr_ok && (wbs_adr == A_BS_SIZE) && wbs_sel[gi])
                                         ? wbs_dat_w[gi*8 +: 8] : bs_size_reg[gi*8 +: 8];
    end

    always_comb begin
        rd_data = 32'd0;
        case (wbs_adr)
            A_CTRL:    rd_data = {30'd0, irq_en_reg, 1'b0};
            A_STATUS:  rd_data = {27'd0, bus_err_reg, timeout_bit, err_reg, done_reg, busy};
            A_BS_ADDR: rd_data = bs_addr_reg;
            A_BS_SIZE: rd_data = bs_size_reg;
            A_LAST:    rd_data = last_stat_reg;
            default:   rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg     <= 1'b0;
            dat_r_reg   <= 32'd0;
            irq_en_reg  <= 1'b0;
            bs_addr_reg <= 32'd0;
            bs_size_reg <= 32'd0;
            irq_reg     <= 1'b0;
        end else begin
            ack_reg     <= wbs_req;
            bs_addr_reg <= bs_addr_next;
            bs_size_reg <= bs_size_next;
            irq_reg     <= irq_en_reg & (done_reg | err_reg | timeout_bit | bus_err_reg);
            if (wbs_req && !wbs_we) begin
                dat_r_reg <= rd_data;
            end
            if (wbs_wr && (wbs_adr == A_CTRL) && wbs_sel[0]) begin
                irq_en_reg <= wbs_dat_w[1];
            end
        end
    end

    // Address/data/direction of the transaction each bus state issues, and where it leads on ack.
    always_comb begin
        bus_adr  = STAT_OFS;
        bus_dat  = 32'd0;
        bus_we   = 1'b0;
        bus_next = S_FIN;
        case (state_reg)
            S_WR_ADDR: begin bus_adr = BS_ADDR_OFS; bus_dat = bs_addr_reg; bus_we = 1'b1; bus_next = S_WR_SIZE; end
            S_WR_SIZE: begin bus_adr = BS_SIZE_OFS; bus_dat = bs_size_reg; bus_we = 1'b1; bus_next = S_WR_TRIG; end
            S_WR_TRIG: begin bus_adr = STAT_OFS;    bus_dat = TRIG_CMD;    bus_we = 1'b1; bus_next = S_WAIT;    end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= 5'd0;
            dat_reg       <= 32'd0;
            wait_cnt_reg  <= 32'd0;
            last_stat_reg <= 32'd0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            bus_err_reg   <= 1'b0;
`ifdef DFX_SEQ_TIMEOUT_EN
            timeout_reg   <= 1'b0;
            poll_cnt_reg  <= 16'd0;
`endif
        end else begin
            // Software clears first; the FSM sets below override them in the same cycle.
            done_reg    <= done_reg & ~w1c_mask[0];
            err_reg     <= err_reg & ~w1c_mask[1];
            bus_err_reg <= bus_err_reg & ~w1c_mask[3];
`ifdef DFX_SEQ_TIMEOUT_EN
            timeout_reg <= timeout_reg & ~w1c_mask[2];
`endif
            case (state_reg)
                S_IDLE: begin
                    if (start_req) begin
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        bus_err_reg  <= 1'b0;
                        wait_cnt_reg <= 32'd0;
                        state_reg    <= S_WR_ADDR;
`ifdef DFX_SEQ_TIMEOUT_EN
                        timeout_reg  <= 1'b0;
                        poll_cnt_reg <= 16'd0;
`endif
                    end
                end
                S_WR_ADDR, S_WR_SIZE, S_WR_TRIG, S_RD_STAT: begin
                    if (!cyc_reg) begin
                        // cyc is low only on entry to a bus state, so this issues exactly once.
                        cyc_reg <= 1'b1;
                        stb_reg <= 1'b1;
                        we_reg  <= bus_we;
                        adr_reg <= bus_adr;
                        dat_reg <= bus_dat;
                    end else begin
                        if (stb_reg && !wbm_stall_i) begin
                            stb_reg <= 1'b0;
                        end
                        if (wbm_err_i) begin
                            cyc_reg     <= 1'b0;
                            stb_reg     <= 1'b0;
                            we_reg      <= 1'b0;
                            dat_reg     <= 32'd0;
                            bus_err_reg <= 1'b1;
                            state_reg   <= S_FIN;
                        end else if (wbm_ack_i) begin
                            cyc_reg <= 1'b0;
                            stb_reg <= 1'b0;
                            we_reg  <= 1'b0;
                            dat_reg <= 32'd0;
                            if (state_reg == S_RD_STAT) begin
                                last_stat_reg <= wbm_dat_i;
`ifdef DFX_SEQ_TIMEOUT_EN
                                poll_cnt_reg  <= poll_cnt_next;
`endif
                                if (wbm_dat_i[1]) begin
                                    err_reg   <= 1'b1;
                                    state_reg <= S_FIN;
                                end else if (wbm_dat_i[2]) begin
                                    done_reg  <= 1'b1;
                                    state_reg <= S_FIN;
`ifdef DFX_SEQ_TIMEOUT_EN
                                end else if (poll_cnt_next == TIMEOUT_POLLS) begin
                                    timeout_reg <= 1'b1;
                                    state_reg   <= S_FIN;
`endif
                                end else begin
                                    state_reg <= S_WAIT;
                                end
                            end else begin
                                state_reg <= bus_next;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == POLL_INTERVAL - 1) begin
                        wait_cnt_reg <= 32'd0;
                        state_reg    <= S_RD_STAT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 32'd1;
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dfx_sequencer.sv
// Directed bench for wb_dfx_sequencer: a scripted DFX controller model on the master port,
// register accesses on the slave port, expected values worked out by hand.
module tb_wb_dfx_sequencer;

    localparam int POLL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  wbs_adr = 3'd0;
    logic [31:0] wbs_dat_w = 32'd0;
    logic [31:0] wbs_dat_r;
    logic [3:0]  wbs_sel = 4'h0;
    logic        wbs_cyc = 1'b0;
    logic        wbs_stb = 1'b0;
    logic        wbs_we = 1'b0;
    logic        wbs_ack, wbs_stall, wbs_err;
    logic [4:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o, wbm_cyc_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_stall_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        irq_o;

    always #5 clk = ~clk;

    wb_dfx_sequencer #(
        .STAT_OFS(5'd0), .BS_ADDR_OFS(5'd6), .BS_SIZE_OFS(5'd7), .TRIG_CMD(32'h0000_0001),
        .POLL_INTERVAL(POLL), .TIMEOUT_POLLS(16'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
        .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
        .wbs_ack(wbs_ack), .wbs_stall(wbs_stall), .wbs_err(wbs_err),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i), .wbm_err_i(wbm_err_i),
        .irq_o(irq_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // DFX controller model state, configured by the main sequence.
    int          done_at = 0;
    logic [31:0] done_val = 32'd0;
    bit          force_done = 1'b0;
    bit          err_on_trig = 1'b0;
    int          stall_left = 0;
    int          rd_count = 0;
    logic [4:0]  log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    int          stb7_cycles = 0;
    int          stb7_unstable = 0;
    logic [31:0] stb7_dat = 32'd0;
    int          rd_dat_bad = 0;
    int          sel_bad = 0;
    int          slave_bad = 0;

    initial begin
        bit          acc;
        logic [4:0]  a_adr;
        logic [31:0] a_dat;
        logic        a_we;
        forever begin
            @(negedge clk);
            acc   = rst_n && wbm_cyc_o && wbm_stb_o && !wbm_stall_i;
            a_adr = wbm_adr_o;
            a_dat = wbm_dat_o;
            a_we  = wbm_we_o;
            if (wbm_stb_o && wbm_we_o && wbm_adr_o == 5'd7) begin
                if (stb7_cycles == 0) stb7_dat = wbm_dat_o;
                else if (wbm_dat_o !== stb7_dat) stb7_unstable++;
                stb7_cycles++;
            end
            if (wbm_stb_o && !wbm_we_o && wbm_dat_o != 32'd0) rd_dat_bad++;
            if (wbm_cyc_o && wbm_sel_o != 4'hF) sel_bad++;
            @(posedge clk);
            #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = 32'd0;
            if (acc) begin
                log_adr.push_back(a_adr);
                log_dat.push_back(a_dat);
                log_we.push_back(a_we);
                if (err_on_trig && a_we && a_adr == 5'd0) begin
                    wbm_err_i = 1'b1;
                    $display("wbm %s adr=%0d dat=0x%08h -> err", a_we ? "wr" : "rd", a_adr, a_dat);
                end else begin
                    wbm_ack_i = 1'b1;
                    if (!a_we) begin
                        rd_count++;
                        wbm_dat_i = (force_done || rd_count == done_at) ? done_val : 32'd0;
                    end
                    $display("wbm %s adr=%0d dat=0x%08h resp=0x%08h", a_we ? "wr" : "rd", a_adr, a_dat, wbm_dat_i);
                end
            end
            wbm_stall_i = 1'b0;
            if (wbm_stb_o && wbm_adr_o == 5'd7 && stall_left > 0) begin
                wbm_stall_i = 1'b1;
                stall_left--;
            end
        end
    end

    function automatic int count_reads();
        int n = 0;
        foreach (log_we[i]) if (!log_we[i]) n++;
        return n;
    endfunction

    function automatic int count_adr(input logic [4:0] a);
        int n = 0;
        foreach (log_adr[i]) if (log_adr[i] == a && log_we[i]) n++;
        return n;
    endfunction

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_we.delete();
        rd_count = 0;
    endtask

    task automatic wbs_write(input logic [2:0] adr, input logic [31:0] dat);
        @(posedge clk); #1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = adr; wbs_dat_w = dat; wbs_sel = 4'hF;
        if (wbs_stall || wbs_err) slave_bad++;
        @(posedge clk); #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        if (!wbs_ack) slave_bad++;
        $display("wbs wr adr=%0d dat=0x%08h ack=%0b", adr, dat, wbs_ack);
    endtask

    task automatic wbs_read(input logic [2:0] adr, output logic [31:0] dat, input bit quiet);
        @(posedge clk); #1;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = adr; wbs_sel = 4'hF;
        if (wbs_stall || wbs_err) slave_bad++;
        @(posedge clk); #1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        if (!wbs_ack) slave_bad++;
        dat = wbs_dat_r;
        if (!quiet) $display("wbs rd adr=%0d dat=0x%08h ack=%0b", adr, dat, wbs_ack);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        bit idle = 1'b0;
        s = 32'd0;
        for (int i = 0; i < 200 && !idle; i++) begin
            wbs_read(3'd1, s, 1'b1);
            if (!s[0]) idle = 1'b1;
        end
        if (!idle) check({tag, "_idle_timeout"}, {31'd0, s[0]}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wbs_read(3'd1, r, 1'b0); check("rst_status", r, 32'd0);
        wbs_read(3'd2, r, 1'b0); check("rst_bs_addr", r, 32'd0);
        wbs_read(3'd4, r, 1'b0); check("rst_last_stat", r, 32'd0);
        repeat (10) @(posedge clk);
        check("rst_no_master_txn", log_adr.size(), 32'd0);

        // Normal run: DONE reported on the third poll.
        wbs_write(3'd2, 32'h0002_0000);
        wbs_write(3'd3, 32'h0001_2340);
        wbs_write(3'd0, 32'h0000_0002);
        wbs_read(3'd5, r, 1'b0); check("unmapped_read", r, 32'd0);
        clear_log();
        done_at = 3; done_val = 32'h4;
        wbs_write(3'd0, 32'h0000_0003);
        wait_idle("normal");
        check("normal_txn_count", log_adr.size(), 32'd6);
        check("normal_w0_adr", {27'd0, log_adr[0]}, 32'd6);
        check("normal_w0_dat", log_dat[0], 32'h0002_0000);
        check("normal_w1_adr", {27'd0, log_adr[1]}, 32'd7);
        check("normal_w1_dat", log_dat[1], 32'h0001_2340);
        check("normal_w2_adr", {27'd0, log_adr[2]}, 32'd0);
        check("normal_w2_dat", log_dat[2], 32'h0000_0001);
        check("normal_reads", count_reads(), 32'd3);
        check("normal_rd_adr", {27'd0, log_adr[5]}, 32'd0);
        wbs_read(3'd1, r, 1'b0); check("normal_status", r, 32'h0000_0002);
        wbs_read(3'd4, r, 1'b0); check("normal_last_stat", r, 32'h0000_0004);
        check("normal_irq", {31'd0, irq_o}, 32'd1);
        wbs_read(3'd0, r, 1'b0); check("ctrl_readback", r, 32'h0000_0002);

        // Clear all sticky bits; interrupt follows one cycle after the flags.
        wbs_write(3'd1, 32'h0000_001E);
        @(posedge clk); #1;
        check("w1c_irq_low", {31'd0, irq_o}, 32'd0);
        wbs_read(3'd1, r, 1'b0); check("w1c_status", r, 32'd0);

        // Stall on the size write: five stalled cycles, accepted on the sixth.
        clear_log();
        stb7_cycles = 0; stb7_unstable = 0;
        stall_left = 5; done_at = 1; done_val = 32'h4;
        wbs_write(3'd0, 32'h0000_0003);
        wait_idle("stall");
        check("stall_stb_cycles", stb7_cycles, 32'd6);
        check("stall_dat_stable", stb7_unstable, 32'd0);
        check("stall_single_write", count_adr(5'd7), 32'd1);
        wbs_read(3'd1, r, 1'b0); check("stall_status", r, 32'h0000_0002);
        wbs_write(3'd1, 32'h0000_001E);

        // DFX error: both error and done bits set, error decoded first.
        clear_log();
        done_at = 1; done_val = 32'h6;
        wbs_write(3'd0, 32'h0000_0003);
        wait_idle("dfx_err");
        wbs_read(3'd1, r, 1'b0); check("dfx_err_status", r, 32'h0000_0004);
        check("dfx_err_reads", count_reads(), 32'd1);
        check("dfx_err_irq", {31'd0, irq_o}, 32'd1);
        wbs_write(3'd1, 32'h0000_0004);
        @(posedge clk); #1;
        check("dfx_err_irq_clr", {31'd0, irq_o}, 32'd0);
        wbs_read(3'd1, r, 1'b0); check("dfx_err_cleared", r, 32'd0);

        // Bus error on the trigger write.
        clear_log();
        err_on_trig = 1'b1;
        wbs_write(3'd0, 32'h0000_0003);
        n = 0;
        while (!wbm_err_i && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("bus_err_seen", {31'd0, wbm_err_i}, 32'd1);
        @(posedge clk);
        wbs_read(3'd1, r, 1'b0); check("bus_err_status_2cyc", r, 32'h0000_0010);
        err_on_trig = 1'b0;
        repeat (3 * POLL) @(posedge clk);
        check("bus_err_no_read", count_reads(), 32'd0);
        check("bus_err_txn_count", log_adr.size(), 32'd3);
        wbs_write(3'd1, 32'h0000_001E);

        // Controller never reports completion.
        clear_log();
        done_at = 0; done_val = 32'h4;
`ifdef DFX_SEQ_TIMEOUT_EN
        wbs_write(3'd0, 32'h0000_0003);
        wait_idle("timeout");
        check("timeout_reads", count_reads(), 32'd4);
        wbs_read(3'd1, r, 1'b0); check("timeout_status", r, 32'h0000_0008);
`else
        wbs_write(3'd0, 32'h0000_0003);
        repeat (60) @(posedge clk);
        check("poll_continues", {31'd0, count_reads() > 4}, 32'd1);
        wbs_read(3'd1, r, 1'b0); check("no_timeout_status", r, 32'h0000_0001);
        force_done = 1'b1;
        wait_idle("no_timeout");
        force_done = 1'b0;
        wbs_read(3'd1, r, 1'b0); check("no_timeout_done", r, 32'h0000_0002);
`endif
        wbs_write(3'd1, 32'h0000_001E);

        // Busy write is acked but dropped; then reset lands in the middle of a status read.
        clear_log();
        done_at = 0;
        wbs_write(3'd0, 32'h0000_0003);
        n = 0;
        while (count_reads() < 1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("first_read_seen", count_reads(), 32'd1);
        slave_bad = 0;
        wbs_write(3'd2, 32'hDEAD_BEEF);
        check("busy_write_ack", slave_bad, 32'd0);
        wbs_read(3'd2, r, 1'b0); check("busy_write_dropped", r, 32'h0002_0000);
        n = 0;
        while (!(wbm_cyc_o && !wbm_we_o) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("rd_cycle_seen", {31'd0, wbm_cyc_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("mid_rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("mid_rst_we", {31'd0, wbm_we_o}, 32'd0);
        check("mid_rst_ack", {31'd0, wbs_ack}, 32'd0);
        check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        wbs_read(3'd1, r, 1'b0); check("post_rst_status", r, 32'd0);
        wbs_read(3'd0, r, 1'b0); check("post_rst_ctrl", r, 32'd0);
        wbs_read(3'd2, r, 1'b0); check("post_rst_bs_addr", r, 32'd0);
        wbs_read(3'd4, r, 1'b0); check("post_rst_last_stat", r, 32'd0);
        repeat (20) @(posedge clk);
        check("post_rst_no_txn", log_adr.size(), 32'd0);

        check("rd_dat_zero", rd_dat_bad, 32'd0);
        check("sel_all_lanes", sel_bad, 32'd0);
        check("slave_ack_timing", slave_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
